mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, number of busy cycles for multiply-class ops (legal range 1..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, number of busy cycles for divide-class ops (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to issue the op on the current edge.
REQ-006 SHALL have port op  input  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu.
REQ-007 SHALL have port a  input  32  rs operand from the register file read port 1.
REQ-008 SHALL have port b  input  32  rt operand from the register file read port 2.
REQ-009 SHALL have port busy  output  1  high while a multi-cycle op is in flight.
REQ-010 SHALL have ports hi and lo  output  32 each  architectural HI and LO registers, read by mfhi/mflo.

Function
REQ-011 SHALL accept start only at an edge where busy=0; start while busy=1 is ignored and has no effect on state.
REQ-012 SHALL ignore start with op 0 or op 11..15: no state change.
REQ-013 SHALL latch a, b and op at the accepting edge; later input changes do not affect the result.
REQ-014 States: IDLE (busy=0) and RUN (busy=1); accepted multi-cycle op moves IDLE->RUN and loads the counter with MULT_CYCLES or DIV_CYCLES.
REQ-015 In RUN the counter decrements each edge; at the edge where it equals 1, hi/lo SHALL take the result and busy SHALL fall, returning to IDLE.
REQ-016 Busy SHALL therefore be high for exactly N cycles; old hi/lo stay visible throughout RUN.
REQ-017 mult/multu SHALL write the 64-bit product of a and b to {hi,lo}: signed for mult and unsigned for multu.
REQ-018 div/divu SHALL write the quotient to lo and the remainder to hi; for div, the quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-019 div of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-020 Divide by zero SHALL leave hi/lo unchanged, but busy still runs for DIV_CYCLES.
REQ-021 mthi/mtlo SHALL write a into hi or lo at the accepting edge, with busy staying 0 (single cycle).
REQ-022 A new start is accepted on the same edge busy falls only if busy was 0 before that edge; i.e. earliest re-issue is the cycle after busy drops.

Reset
REQ-023 Reset asserted at any time, including mid-RUN, SHALL immediately force busy=0, hi=0, lo=0, counter=0 and state IDLE; the in-flight op is discarded.
REQ-024 The first start SHALL be accepted at the first rising edge after reset deasserts.

Configuration
REQ-025 Macro MDU_MADD_EN defined: ops 7..10 are supported; they accumulate into the old {hi,lo}, which is latched at the accepting edge.
REQ-026 madd/maddu compute {hi,lo} + a*b (signed/unsigned product); msub/msubu compute {hi,lo} - a*b; all four take MULT_CYCLES and wrap modulo 2^64.
REQ-027 Macro MDU_MADD_EN undefined: ops 7..10 are treated as illegal per REQ-012 and no accumulate hardware is present.

Structure
REQ-028 A shared package SHALL hold the op-code constants and the default cycle counts.
REQ-029 One sub-module, mdu_calc, SHALL compute the combinational 64-bit result from the latched operands, op and old {hi,lo}; mdu holds the FSM, counter and HI/LO registers.

Verification
REQ-030 Scenario: mult with a=0xFFFFFFFF, b=2 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-031 Scenario: divu with a=7, b=2 -> busy high for 10 cycles, then lo=3, hi=1; div with a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 Scenario: mthi with a=0x12345678 -> hi=0x12345678 after one edge with busy never asserted; then div with b=0 -> after 10 busy cycles, hi/lo are unchanged.
REQ-033 Scenario: start mult, pulse reset in its 3rd busy cycle -> busy=0, hi=lo=0 immediately; a start asserted while busy is later shown to be ignored.
REQ-034 Scenario (MDU_MADD_EN): hi=0, lo=0xFFFFFFFF, then maddu with a=1, b=1 -> hi=1, lo=0 after 5 cycles.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared op codes, default latencies and FSM state type for the multiply/divide unit.
// Optional accumulate ops (madd/maddu/msub/msubu) are enabled by defining MDU_MADD_EN.
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_t;

    // Multiply-class ops share the MULT_CYCLES latency.
    function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
               (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`else
        return (op == OP_MULT) || (op == OP_MULTU);
`endif
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit result for the latched op: products, quotient/remainder and,
// when MDU_MADD_EN is defined, accumulate into the previous {hi,lo}.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [63:0] i_hilo,
    output logic [63:0] o_res,
    output logic        o_wr
);

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic               w_sgn;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_b_nz;
    logic        [31:0] w_a_mag;
    logic        [31:0] w_b_mag;
    logic        [31:0] w_divisor;
    logic        [31:0] w_q_mag;
    logic        [31:0] w_r_mag;
    logic        [31:0] w_q;
    logic        [31:0] w_r;

    assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign w_sgn     = (i_op == OP_DIV);
    assign w_a_neg   = w_sgn & i_a[31];
    assign w_b_neg   = w_sgn & i_b[31];
    assign w_a_mag   = w_a_neg ? (32'd0 - i_a) : i_a;
    assign w_b_mag   = w_b_neg ? (32'd0 - i_b) : i_b;
    assign w_b_nz    = (i_b != 32'd0);
    assign w_divisor = w_b_nz ? w_b_mag : 32'd1;
    assign w_q_mag   = w_a_mag / w_divisor;
    assign w_r_mag   = w_a_mag % w_divisor;
    assign w_q       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r       = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        o_res = i_hilo;
        o_wr  = 1'b0;
        case (i_op)
            OP_MULT: begin
                o_res = $unsigned(w_prod_s);
                o_wr  = 1'b1;
            end
            OP_MULTU: begin
                o_res = w_prod_u;
                o_wr  = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                o_res = {w_r, w_q};
                o_wr  = w_b_nz;
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                o_res = i_hilo + $unsigned(w_prod_s);
                o_wr  = 1'b1;
            end
            OP_MADDU: begin
                o_res = i_hilo + w_prod_u;
                o_wr  = 1'b1;
            end
            OP_MSUB: begin
                o_res = i_hilo - $unsigned(w_prod_s);
                o_wr  = 1'b1;
            end
            OP_MSUBU: begin
                o_res = i_hilo - w_prod_u;
                o_wr  = 1'b1;
            end
`endif
            default: begin
                o_res = i_hilo;
                o_wr  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Define MDU_MADD_EN to add madd/maddu/msub/msubu accumulate ops.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_t  r_state;
    mdu_state_t  w_next_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_next_cnt;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        w_accept;
    logic        w_done;
    logic [63:0] w_res;
    logic        w_wr;

    assign w_accept = start && (r_state == S_IDLE);
    assign w_done   = (r_state == S_RUN) && (r_cnt == 4'd1);

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (start && is_mul_op(op)) begin
                    w_next_state = S_RUN;
                    w_next_cnt   = 4'(MULT_CYCLES);
                end else if (start && is_div_op(op)) begin
                    w_next_state = S_RUN;
                    w_next_cnt   = 4'(DIV_CYCLES);
                end
            end
            S_RUN: begin
                if (r_cnt == 4'd1) begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = 4'd0;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept && (op == OP_MTHI)) begin
                r_hi <= a;
            end else if (w_accept && (op == OP_MTLO)) begin
                r_lo <= a;
            end else if (w_done && w_wr) begin
                r_hi <= w_res[63:32];
                r_lo <= w_res[31:0];
            end
        end
    end

    // Operand capture is pure data; a stale value is harmless because the FSM gates its use.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op <= op;
            r_a  <= a;
            r_b  <= b;
        end
    end

    // HI/LO cannot change while RUN, so they already hold the accumulate base captured at issue.
    mdu_calc u_calc (
        .i_op   (r_op),
        .i_a    (r_a),
        .i_b    (r_b),
        .i_hilo ({r_hi, r_lo}),
        .o_res  (w_res),
        .o_wr   (w_wr)
    );

    assign busy = (r_state == S_RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu with default latencies (5 multiply, 10 divide).
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    mdu dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts busy cycles from the one following the accepting edge; bounded.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (busy === 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            if (busy === 1'b1) cyc++;
        end
    endtask

    // Returns #1 after the accepting edge, with operands scrambled afterwards.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 4'd0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);

        // release reset and request mult in the same cycle: first edge must accept
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        op    = 4'd1;
        a     = 32'hFFFF_FFFF;
        b     = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        check("mult_busy_rise", {63'd0, busy}, 64'd1);
        check("mult_old_hilo", {hi, lo}, 64'd0);
        wait_done(n);
        check("mult_cycles", 64'(n), 64'd5);
        check("mult_result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);

        issue(4'd2, 32'hFFFF_FFFF, 32'd2);
        wait_done(n);
        check("multu_result", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        issue(4'd4, 32'd7, 32'd2);
        wait_done(n);
        check("divu_cycles", 64'(n), 64'd10);
        check("divu_result", {hi, lo}, 64'h0000_0001_0000_0003);

        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        check("div_neg_dividend", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        issue(4'd3, 32'd7, 32'hFFFF_FFFE);
        wait_done(n);
        check("div_neg_divisor", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        check("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);

        issue(4'd5, 32'h1234_5678, 32'd0);
        check("mthi_busy", {63'd0, busy}, 64'd0);
        check("mthi_result", {hi, lo}, 64'h1234_5678_8000_0000);

        issue(4'd3, 32'd99, 32'd0);
        wait_done(n);
        check("divzero_cycles", 64'(n), 64'd10);
        check("divzero_hilo", {hi, lo}, 64'h1234_5678_8000_0000);

        issue(4'd0, 32'h5555_5555, 32'd1);
        check("op0_busy", {63'd0, busy}, 64'd0);
        check("op0_hilo", {hi, lo}, 64'h1234_5678_8000_0000);

        issue(4'd12, 32'h5555_5555, 32'd1);
        check("op12_busy", {63'd0, busy}, 64'd0);
        check("op12_hilo", {hi, lo}, 64'h1234_5678_8000_0000);

`ifdef MDU_MADD_EN
        issue(4'd5, 32'd0, 32'd0);
        issue(4'd6, 32'hFFFF_FFFF, 32'd0);
        issue(4'd8, 32'd1, 32'd1);
        wait_done(n);
        check("maddu_cycles", 64'(n), 64'd5);
        check("maddu_result", {hi, lo}, 64'h0000_0001_0000_0000);
        issue(4'd10, 32'd2, 32'd3);
        wait_done(n);
        check("msubu_result", {hi, lo}, 64'h0000_0000_FFFF_FFFA);
`else
        issue(4'd8, 32'd1, 32'd1);
        check("maddu_off_busy", {63'd0, busy}, 64'd0);
        check("maddu_off_hilo", {hi, lo}, 64'h1234_5678_8000_0000);
`endif

        // mtlo held high through the whole mult: ignored while busy, taken the cycle after
        issue(4'd1, 32'd3, 32'd5);
        start = 1'b1;
        op    = 4'd6;
        a     = 32'h0000_0011;
        wait_done(n);
        check("held_start_cycles", 64'(n), 64'd5);
        check("held_start_ignored", {hi, lo}, 64'h0000_0000_0000_000F);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("reissue_after_drop", {hi, lo}, 64'h0000_0000_0000_0011);

        issue(4'd5, 32'h0000_ABCD, 32'd0);
        issue(4'd1, 32'h0001_0000, 32'h0001_0000);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrun_reset_busy", {63'd0, busy}, 64'd0);
        check("midrun_reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("discarded_busy", {63'd0, busy}, 64'd0);
        check("discarded_hilo", {hi, lo}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
